// File: rtl/multi_stock_quote_engine.sv
// Multi-stock market-making quote engine.
// Each accepted top-of-book update folds its mid price into a per-stock sliding
// window. Once that window is full, a buy/sell quote is produced around an
// inventory-skewed reference price. The half-spread widens with the distance
// between the current mid and the window mean. Quotes never cross the book.
// Pipeline: S1 window update, S2 mean/deviation/reference, S3 half-spread and
// raw quotes, then a final clamp-to-book output register.
module multi_stock_quote_engine #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_STOCKS  = 4,
    parameter int WINDOW_LOG2 = 5,
    parameter int INV_WIDTH   = 16,
    parameter int DEV_SHIFT   = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic [DATA_WIDTH-1:0]         i_best_bid,
    input  logic [DATA_WIDTH-1:0]         i_best_ask,
    input  logic signed [INV_WIDTH-1:0]   i_inventory,
    input  logic                          i_clear,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_clear_id,
    input  logic [DATA_WIDTH-1:0]         i_base_half_spread,
    input  logic [DATA_WIDTH-1:0]         i_skew_per_unit,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_buy_price,
    output logic [DATA_WIDTH-1:0]         o_sell_price
);
    localparam int ID_W   = $clog2(NUM_STOCKS);
    localparam int DEPTH  = 1 << WINDOW_LOG2;
    localparam int SUM_W  = DATA_WIDTH + WINDOW_LOG2;
    localparam int CNT_W  = WINDOW_LOG2 + 1;
    localparam int PROD_W = INV_WIDTH + DATA_WIDTH + 1;
    localparam int REF_W  = PROD_W + 1;
    localparam logic [DATA_WIDTH-1:0] MAX_PRICE = '1;

    // The entire pipeline advances together, bubbles included, whenever the
    // output register is free or being drained.
    logic advance;
    logic accept;
    logic in_range;
    logic clr_same;
    assign advance  = !(o_valid && !i_ready);
    assign o_ready  = advance;
    assign accept   = i_valid && advance;
    assign in_range = ({1'b0, i_stock_id} < (ID_W + 1)'(NUM_STOCKS));
    assign clr_same = i_clear && (i_clear_id == i_stock_id);

    // ---------------- S1: per-stock window read-modify-write ----------------
    logic [WINDOW_LOG2-1:0] ptr_vec [NUM_STOCKS];
    logic [CNT_W-1:0]       cnt_vec [NUM_STOCKS];
    logic [SUM_W-1:0]       sum_vec [NUM_STOCKS];

    // Combinational read is required here. A same-stock update on the next
    // cycle must observe this cycle's write.
    logic [DATA_WIDTH-1:0]  mid_mem [NUM_STOCKS][DEPTH];

    logic [ID_W-1:0]        sel_idx;
    logic [WINDOW_LOG2-1:0] sel_ptr;
    logic [WINDOW_LOG2-1:0] wr_ptr;
    logic [CNT_W-1:0]       sel_cnt;
    logic [CNT_W-1:0]       new_cnt;
    logic [SUM_W-1:0]       sel_sum;
    logic [SUM_W-1:0]       new_sum;
    logic [DATA_WIDTH:0]    mid_wide;
    logic [DATA_WIDTH-1:0]  mid;
    logic [DATA_WIDTH-1:0]  oldest;
    logic                   window_full;
    logic                   window_ready;

    assign sel_idx      = in_range ? i_stock_id : '0;
    assign sel_ptr      = ptr_vec[sel_idx];
    assign sel_cnt      = cnt_vec[sel_idx];
    assign sel_sum      = sum_vec[sel_idx];
    assign mid_wide     = {1'b0, i_best_bid} + {1'b0, i_best_ask};
    assign mid          = DATA_WIDTH'(mid_wide >> 1);
    assign oldest       = mid_mem[sel_idx][sel_ptr];
    assign window_full  = sel_cnt[WINDOW_LOG2];
    assign new_sum      = window_full ? (sel_sum - SUM_W'(oldest) + SUM_W'(mid))
                                      : (sel_sum + SUM_W'(mid));
    assign new_cnt      = window_full ? sel_cnt : (sel_cnt + CNT_W'(1));
    assign window_ready = (new_cnt == CNT_W'(DEPTH));
    // A coincident clear restarts the window, so this sample lands in slot 0.
    assign wr_ptr       = clr_same ? '0 : sel_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STOCKS; gi++) begin : g_stock
            logic [WINDOW_LOG2-1:0] ptr_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic [SUM_W-1:0]       sum_reg;
            logic                   upd_hit;
            logic                   clr_hit;

            assign upd_hit = accept && in_range && (i_stock_id == ID_W'(gi));
            assign clr_hit = i_clear && (i_clear_id == ID_W'(gi));

            // Per-stock window bookkeeping. A clear wins, and a same-cycle
            // update becomes the first sample of the new window.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    ptr_reg <= '0;
                    cnt_reg <= '0;
                    sum_reg <= '0;
                end else if (clr_hit) begin
                    if (upd_hit) begin
                        ptr_reg <= WINDOW_LOG2'(1);
                        cnt_reg <= CNT_W'(1);
                        sum_reg <= SUM_W'(mid);
                    end else begin
                        ptr_reg <= '0;
                        cnt_reg <= '0;
                        sum_reg <= '0;
                    end
                end else if (upd_hit) begin
                    ptr_reg <= ptr_reg + WINDOW_LOG2'(1);
                    cnt_reg <= new_cnt;
                    sum_reg <= new_sum;
                end
            end

            assign ptr_vec[gi] = ptr_reg;
            assign cnt_vec[gi] = cnt_reg;
            assign sum_vec[gi] = sum_reg;
        end
    endgenerate

    // Mid-price history store. Its contents are never reset; count gates their use.
    always_ff @(posedge i_clk) begin
        if (accept && in_range) begin
            mid_mem[sel_idx][wr_ptr] <= mid;
        end
    end

    logic                        s1_valid;
    logic [DATA_WIDTH-1:0]       s1_mid;
    logic [SUM_W-1:0]            s1_sum;
    logic [DATA_WIDTH-1:0]       s1_bid;
    logic [DATA_WIDTH-1:0]       s1_ask;
    logic signed [INV_WIDTH-1:0] s1_inv;
    logic [ID_W-1:0]             s1_id;

    // S1 register: only a full-window, uncleared, in-range update becomes a quote.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_valid <= 1'b0;
            s1_mid   <= '0;
            s1_sum   <= '0;
            s1_bid   <= '0;
            s1_ask   <= '0;
            s1_inv   <= '0;
            s1_id    <= '0;
        end else if (advance) begin
            s1_valid <= accept && in_range && !clr_same && window_ready;
            s1_mid   <= mid;
            s1_sum   <= new_sum;
            s1_bid   <= i_best_bid;
            s1_ask   <= i_best_ask;
            s1_inv   <= i_inventory;
            s1_id    <= i_stock_id;
        end
    end

    // ---------------- S2: mean, deviation, skewed reference ----------------
    logic [DATA_WIDTH-1:0]    mean;
    logic [DATA_WIDTH-1:0]    dev;
    logic signed [PROD_W-1:0] inv_ext;
    logic signed [PROD_W-1:0] skew_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [REF_W-1:0]  ref_wide;
    logic [DATA_WIDTH-1:0]    ref_sat;

    assign mean     = DATA_WIDTH'(s1_sum >> WINDOW_LOG2);
    assign dev      = (s1_mid >= mean) ? (s1_mid - mean) : (mean - s1_mid);
    assign inv_ext  = {{(PROD_W - INV_WIDTH){s1_inv[INV_WIDTH-1]}}, s1_inv};
    assign skew_ext = {{(PROD_W - DATA_WIDTH){1'b0}}, i_skew_per_unit};
    assign prod     = inv_ext * skew_ext;
    assign ref_wide = $signed({{(REF_W - DATA_WIDTH){1'b0}}, s1_mid})
                    - $signed({prod[PROD_W-1], prod});
    assign ref_sat  = ref_wide[REF_W-1]                 ? '0 :
                      (|ref_wide[REF_W-2:DATA_WIDTH])   ? MAX_PRICE :
                                                          ref_wide[DATA_WIDTH-1:0];

    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_ref;
    logic [DATA_WIDTH-1:0] s2_dev;
    logic [DATA_WIDTH-1:0] s2_bid;
    logic [DATA_WIDTH-1:0] s2_ask;
    logic [ID_W-1:0]       s2_id;

    // S2 register: reference price and deviation move forward with the book.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2_valid <= 1'b0;
            s2_ref   <= '0;
            s2_dev   <= '0;
            s2_bid   <= '0;
            s2_ask   <= '0;
            s2_id    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_ref   <= ref_sat;
            s2_dev   <= dev;
            s2_bid   <= s1_bid;
            s2_ask   <= s1_ask;
            s2_id    <= s1_id;
        end
    end

    // ---------------- S3: half-spread and raw quotes ----------------
    logic [DATA_WIDTH:0]   half_wide;
    logic [DATA_WIDTH-1:0] half;
    logic [DATA_WIDTH-1:0] buy_raw;
    logic [DATA_WIDTH:0]   sell_wide;
    logic [DATA_WIDTH-1:0] sell_raw;

    assign half_wide = {1'b0, i_base_half_spread} + {1'b0, (s2_dev >> DEV_SHIFT)};
    assign half      = half_wide[DATA_WIDTH] ? MAX_PRICE : half_wide[DATA_WIDTH-1:0];
    assign buy_raw   = (s2_ref >= half) ? (s2_ref - half) : '0;
    assign sell_wide = {1'b0, s2_ref} + {1'b0, half};
    assign sell_raw  = sell_wide[DATA_WIDTH] ? MAX_PRICE : sell_wide[DATA_WIDTH-1:0];

    logic                  s3_valid;
    logic [DATA_WIDTH-1:0] s3_buy;
    logic [DATA_WIDTH-1:0] s3_sell;
    logic [DATA_WIDTH-1:0] s3_bid;
    logic [DATA_WIDTH-1:0] s3_ask;
    logic [ID_W-1:0]       s3_id;

    // S3 register: saturated quotes before the book clamp.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s3_valid <= 1'b0;
            s3_buy   <= '0;
            s3_sell  <= '0;
            s3_bid   <= '0;
            s3_ask   <= '0;
            s3_id    <= '0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_buy   <= buy_raw;
            s3_sell  <= sell_raw;
            s3_bid   <= s2_bid;
            s3_ask   <= s2_ask;
            s3_id    <= s2_id;
        end
    end

    // Output register: clamp so the bid is never raised and the ask never lowered.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid      <= 1'b0;
            o_stock_id   <= '0;
            o_buy_price  <= '0;
            o_sell_price <= '0;
        end else if (advance) begin
            o_valid      <= s3_valid;
            o_stock_id   <= s3_id;
            o_buy_price  <= (s3_buy < s3_bid) ? s3_buy : s3_bid;
            o_sell_price <= (s3_sell > s3_ask) ? s3_sell : s3_ask;
        end
    end

endmodule

// File: tb/tb_multi_stock_quote_engine.sv
// Directed bench for multi_stock_quote_engine with a quote scoreboard.
module tb_multi_stock_quote_engine;
    localparam int DW    = 32;
    localparam int NS    = 3;
    localparam int WL    = 2;
    localparam int IW    = 16;
    localparam int DS    = 0;
    localparam int DEPTH = 1 << WL;
    localparam int IDW   = 2;
    localparam longint MAXP = 64'h0000_0000_FFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic [IDW-1:0]       i_stock_id = '0;
    logic [DW-1:0]        i_best_bid = '0;
    logic [DW-1:0]        i_best_ask = '0;
    logic signed [IW-1:0] i_inventory = '0;
    logic                 i_clear = 1'b0;
    logic [IDW-1:0]       i_clear_id = '0;
    logic [DW-1:0]        i_base_half_spread = '0;
    logic [DW-1:0]        i_skew_per_unit = '0;
    logic                 o_valid;
    logic                 i_ready = 1'b1;
    logic [IDW-1:0]       o_stock_id;
    logic [DW-1:0]        o_buy_price;
    logic [DW-1:0]        o_sell_price;

    always #5 clk = ~clk;

    multi_stock_quote_engine #(
        .DATA_WIDTH (DW),
        .NUM_STOCKS (NS),
        .WINDOW_LOG2(WL),
        .INV_WIDTH  (IW),
        .DEV_SHIFT  (DS)
    ) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_stock_id        (i_stock_id),
        .i_best_bid        (i_best_bid),
        .i_best_ask        (i_best_ask),
        .i_inventory       (i_inventory),
        .i_clear           (i_clear),
        .i_clear_id        (i_clear_id),
        .i_base_half_spread(i_base_half_spread),
        .i_skew_per_unit   (i_skew_per_unit),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_stock_id        (o_stock_id),
        .o_buy_price       (o_buy_price),
        .o_sell_price      (o_sell_price)
    );

    typedef struct {
        longint id;
        longint buy;
        longint sell;
    } quote_t;

    quote_t sb[$];
    longint hist [NS][DEPTH];
    int     hcnt [NS];
    longint base_half = 1;
    longint skew      = 3;
    int     n_checks  = 0;
    int     n_pass    = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: newest-first history per stock, quote when window full.
    task automatic model_push(input int id, input longint bid, input longint ask,
                              input longint inv, input bit clr);
        longint mid, sum, mean, dev, refp, half, buy, sell;
        quote_t q;
        if (id >= NS) return;
        mid = (bid + ask) >> 1;
        if (clr) hcnt[id] = 0;
        for (int k = DEPTH - 1; k > 0; k--) hist[id][k] = hist[id][k-1];
        hist[id][0] = mid;
        if (hcnt[id] < DEPTH) hcnt[id]++;
        if (hcnt[id] != DEPTH) return;
        sum = 0;
        for (int k = 0; k < DEPTH; k++) sum += hist[id][k];
        mean = sum / DEPTH;
        dev  = (mid > mean) ? mid - mean : mean - mid;
        refp = mid - inv * skew;
        if (refp < 0) refp = 0;
        if (refp > MAXP) refp = MAXP;
        half = base_half + (dev >> DS);
        if (half > MAXP) half = MAXP;
        buy  = (refp >= half) ? refp - half : 0;
        sell = refp + half;
        if (sell > MAXP) sell = MAXP;
        if (buy > bid) buy = bid;
        if (sell < ask) sell = ask;
        q.id = id; q.buy = buy; q.sell = sell;
        sb.push_back(q);
    endtask

    task automatic set_cfg(input longint bh, input longint sk);
        base_half = bh;
        skew = sk;
        i_base_half_spread = DW'(bh);
        i_skew_per_unit = DW'(sk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one update; it is accepted on the first edge with o_ready high.
    task automatic send(input int id, input longint bid, input longint ask,
                        input longint inv, input bit clr);
        int waited;
        waited = 0;
        i_valid = 1'b1;
        i_stock_id = IDW'(id);
        i_best_bid = DW'(bid);
        i_best_ask = DW'(ask);
        i_inventory = IW'(inv);
        i_clear = clr;
        i_clear_id = IDW'(id);
        @(negedge clk);
        while (!o_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!o_ready) check("send_timeout", longint'(o_ready), 1);
        else model_push(id, bid, ask, inv, clr);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic do_clear(input int id);
        i_clear = 1'b1;
        i_clear_id = IDW'(id);
        hcnt[id] = 0;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
    endtask

    task automatic flush_model();
        sb.delete();
        for (int s = 0; s < NS; s++) hcnt[s] = 0;
    endtask

    // Output monitor: every handshake must match the oldest expected quote.
    always @(negedge clk) begin : monitor
        quote_t q;
        if (o_valid && i_ready) begin
            $display("quote stock=%0d buy=%0d sell=%0d", o_stock_id, o_buy_price, o_sell_price);
            if (sb.size() == 0) begin
                check("unexpected_quote", longint'(o_valid), 0);
            end else begin
                q = sb.pop_front();
                check("quote_id", longint'(o_stock_id), q.id);
                check("quote_buy", longint'(o_buy_price), q.buy);
                check("quote_sell", longint'(o_sell_price), q.sell);
            end
        end
    end

    initial begin
        int w;
        for (int s = 0; s < NS; s++) hcnt[s] = 0;
        set_cfg(1, 3);
        #2 rst = 1'b1;
        #1;
        check("rst_o_valid", longint'(o_valid), 0);
        check("rst_o_ready", longint'(o_ready), 1);
        check("rst_buy", longint'(o_buy_price), 0);
        check("rst_sell", longint'(o_sell_price), 0);
        check("rst_id", longint'(o_stock_id), 0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Fill stock 0: only the 4th update quotes, exactly 3 cycles later.
        for (int k = 0; k < 3; k++) send(0, 100, 102, 0, 0);
        send(0, 100, 102, 0, 0);
        check("lat_0", longint'(o_valid), 0);
        for (int k = 1; k < 3; k++) begin
            idle(1);
            check("lat_mid", longint'(o_valid), 0);
        end
        idle(1);
        check("lat_3", longint'(o_valid), 1);

        // Roll, issued back-to-back on the same stock: buy 102, sell 116.
        send(0, 108, 110, 0, 0);

        // Skew on stock 1: the last update has inventory +2, giving buy 94 and sell 102.
        for (int k = 0; k < 4; k++) send(1, 100, 102, 0, 0);
        send(1, 100, 102, 2, 0);
        idle(6);

        // Saturation on stock 2: reference clamps to 0.
        set_cfg(1, 10);
        for (int k = 0; k < 4; k++) send(2, 0, 2, 5, 0);
        idle(6);
        set_cfg(1, 3);

        // An out-of-range stock id is ignored. The next stock-0 quote proves state is intact.
        send(3, 500, 502, 0, 0);
        send(0, 104, 106, 0, 0);
        idle(6);

        // Backpressure: hold i_ready low with quotes queued.
        i_ready = 1'b0;
        send(2, 10, 12, 0, 0);
        send(2, 20, 22, 0, 0);
        send(2, 30, 32, 1, 0);
        idle(1);
        for (int k = 0; k < 6; k++) begin
            check("bp_valid", longint'(o_valid), 1);
            check("bp_ready", longint'(o_ready), 0);
            check("bp_buy_hold", longint'(o_buy_price), sb[0].buy);
            check("bp_sell_hold", longint'(o_sell_price), sb[0].sell);
            if (k < 5) idle(1);
        end
        i_ready = 1'b1;
        idle(8);

        // Clear coincident with an update on stock 0 restarts the window.
        send(0, 200, 202, 0, 1);
        for (int k = 0; k < 3; k++) send(0, 200 + 4 * k, 202 + 4 * k, 0, 0);
        idle(6);

        // A clear behind an in-flight quote does not cancel that quote.
        send(1, 120, 122, 0, 0);
        do_clear(1);
        send(1, 120, 122, 0, 0);
        idle(6);

        // Reset mid-pipeline drops everything in flight.
        for (int k = 0; k < 3; k++) send(2, 50, 52, 0, 0);
        @(posedge clk);
        #2;
        check("pre_rst_valid", longint'(o_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", longint'(o_valid), 0);
        check("mid_rst_ready", longint'(o_ready), 1);
        check("mid_rst_buy", longint'(o_buy_price), 0);
        flush_model();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        idle(8);
        for (int k = 0; k < 4; k++) send(2, 60, 64, 0, 0);

        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        idle(2);
        check("scoreboard_empty", longint'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
